instr_encoder_loader: RTL and testbench
=======================================

# instr_encoder_loader

Streams instruction-field requests, packs each into a 32-bit RV32I word (R/I/S/B/U/J formats), and writes the words into instruction memory at consecutive addresses. It is the encoding-side counterpart of the instruction decoder. It sits between the boot/debug controller and the IMEM write port, and preloads programs before the core is released from reset. A 4-deep FIFO decouples request acceptance from IMEM back-pressure.

## Interface
Parameters:
- FIFO_DEPTH, 4: encoded-word buffer depth; power of two, ≥2.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  pulse; begins a load session at base_addr.
- stop  in  1  pulse; ends the session after the FIFO drains.
- base_addr  in  32  first IMEM byte address; bits [1:0] are ignored and forced to 0.
- req_valid  in  1  field request valid.
- req_ready  out  1  request accepted when both req_valid and req_ready are 1.
- req_fmt  in  3  format code, from the package: R=0, I=1, S=2, B=3, U=4, J=5; codes 6 and 7 are illegal.
- req_opcode  in  7  opcode field.
- req_funct3  in  3  funct3 field.
- req_funct7  in  7  funct7 field.
- req_rd, req_rs1, req_rs2  in  5 each  register fields.
- req_imm  in  32  immediate as a signed byte value.
- imem_we  out  1  write request.
- imem_ready  in  1  write accepted when both imem_we and imem_ready are 1.
- imem_addr  out  32  write address.
- imem_wdata  out  32  encoded word.
- busy  out  1  high in the RUN and FLUSH states.
- done  out  1  high in the DONE state.
- word_count  out  16  words written this session; saturates at 0xFFFF.
- err  out  1  sticky; set on any rejected request; cleared by start.

## Operation
State machine:
- IDLE: `start` moves to RUN. All other inputs are ignored.
- RUN: `stop` moves to FLUSH. `start` is ignored.
- FLUSH: moves to DONE once the FIFO is empty and no write is outstanding.
- DONE: `start` moves to RUN.

Session start (`start` taken in IDLE or DONE):
- Load the address pointer from {base_addr[31:2], 2'b00}.
- Clear word_count and err.

Request acceptance:
- req_ready = (state == RUN) && (fifo_count < FIFO_DEPTH).
- The full check does not account for a same-cycle pop.

Encoding, fields from MSB to LSB:
- R: funct7 | rs2 | rs1 | funct3 | rd | opcode.
- I: imm[11:0] | rs1 | funct3 | rd | opcode. Shift callers place funct7 in imm[11:5].
- S: imm[11:5] | rs2 | rs1 | funct3 | imm[4:0] | opcode.
- B: imm[12] | imm[10:5] | rs2 | rs1 | funct3 | imm[4:1] | imm[11] | opcode.
- U: imm[31:12] | rd | opcode.
- J: imm[20] | imm[10:1] | imm[11] | imm[19:12] | rd | opcode.
- Unused fields are ignored.

Range checks. A request failing any check is accepted, dropped (not pushed), and sets err:
- I and S: imm must lie in [-2048, 2047].
- B: imm in [-4096, 4094] and imm[0] == 0.
- J: imm in [-2^20, 2^20 - 2] and imm[0] == 0.
- U: imm[11:0] == 0.
- req_fmt of 6 or 7 is always rejected.

Write side:
- The FIFO head drives imem_wdata.
- imem_we = FIFO not empty.
- On a write handshake: pop the FIFO, add 4 to the pointer (wrapping 0xFFFFFFFC to 0x00000000), and increment word_count.

Simultaneous events:
- Push and pop in the same cycle leave fifo_count unchanged.
- `start` and `stop` together in IDLE or DONE: `start` wins.
- `stop` in RUN in the same cycle as an accepted request: the request is still encoded and written.

Reset:
- rst_n = 0 at any point, including mid-session, discards FIFO contents.
- Reset values: state IDLE, req_ready 0, imem_we 0, imem_addr 0, imem_wdata 0, busy 0, done 0, word_count 0, err 0.

## Timing
- The encoded word is registered into the FIFO on the clock edge ending handshake cycle N.
- imem_we is high in cycle N+1 at the earliest.
- Sustained throughput is 1 word/cycle when imem_ready is held high.
- While imem_ready = 0, imem_we, imem_addr and imem_wdata hold stable.
- busy falls, and done rises, in the cycle after the last write handshake in FLUSH. FLUSH with an empty FIFO reaches DONE in 1 cycle.
- done stays high until `start` or reset.

## Structure
- Shared package `rv_isa_pkg`:
  - format codes;
  - the opcode constants (OPCODE_R … OPCODE_J), shared with the decoder;
  - immediate range limits.
- Sub-module `instr_fifo`: synchronous FIFO, parameterised width and depth, with count output and full/empty flags.
- Format packing and range checks are combinational logic in the top module, ahead of the FIFO push.

## Test plan
- I-format, opcode 0x13, rd=1, rs1=0, imm=5 (addi x1,x0,5), base_addr=0x100 -> one write, 0x00500093 at 0x100; word_count=1.
- S-format, opcode 0x23, funct3=2, rs1=1, rs2=2, imm=8, then J-format, opcode 0x6F, rd=1, imm=8 -> 0x0020A423 at 0x100, then 0x008000EF at 0x104.
- B-format with imm=3, then U-format, opcode 0x37, rd=5, imm=0x12345000 -> err=1, the B request is dropped, one write of 0x123452B7 at base_addr.
- Hold imem_ready=0 with a stream of 6 requests -> req_ready falls after 4 accepts and outputs hold stable. Release -> 6 in-order writes at +0, +4 … +20.
- base_addr=0xFFFFFFFC, 2 requests -> writes at 0xFFFFFFFC then 0x00000000.
- Assert rst_n=0 with 3 words queued, then `start` -> no stale writes; all reset values hold; the new session begins cleanly.

Source files
------------

// File: rtl/rv_isa_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv_isa_pkg
// Description : RV32I constants shared by the instruction encoder/loader and
//               the decoder. Holds the format codes, the base opcodes and the
//               legal immediate ranges of each format.
// Revision    : 1.0 - initial release
// ============================================================================
package rv_isa_pkg;

  // Request format codes. Codes 6 and 7 are illegal.
  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  localparam logic [6:0] OPCODE_R = 7'h33;
  localparam logic [6:0] OPCODE_I = 7'h13;
  localparam logic [6:0] OPCODE_S = 7'h23;
  localparam logic [6:0] OPCODE_B = 7'h63;
  localparam logic [6:0] OPCODE_U = 7'h37;
  localparam logic [6:0] OPCODE_J = 7'h6F;

  // Signed immediate limits. B and J additionally require an even offset.
  localparam int IMM12_MIN = -2048;
  localparam int IMM12_MAX = 2047;
  localparam int IMM13_MIN = -4096;
  localparam int IMM13_MAX = 4094;
  localparam int IMM21_MIN = -1048576;
  localparam int IMM21_MAX = 1048574;

endpackage
`default_nettype wire

// File: rtl/instr_fifo.sv
`default_nettype none
// ============================================================================
// Module      : instr_fifo
// Description : Synchronous FIFO with occupancy count and full/empty flags.
//               Storage is cleared on reset so the read port is 0 afterwards.
// Revision    : 1.0 - initial release
// Ports       : clk, rst_n (sync, active low)
//               push_i/wdata_i  - write side (ignored when full)
//               pop_i/rdata_o   - read side, rdata_o is the head (ignored
//                                 when empty)
//               count_o, full_o, empty_o - occupancy status
// ============================================================================
module instr_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             w_push;
  logic             w_pop;

  assign w_push = push_i && !full_o;
  assign w_pop  = pop_i && !empty_o;

  // Depth is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_push) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (w_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/instr_encoder_loader.sv
`default_nettype none
// ============================================================================
// Module      : instr_encoder_loader
// Description : Packs RV32I field requests into 32-bit instruction words and
//               writes them to IMEM at consecutive word addresses during a
//               load session (start ... stop). A small FIFO decouples request
//               acceptance from IMEM back-pressure.
// Revision    : 1.0 - initial release
// Ports       : clk, rst_n (sync, active low)
//               start/stop/base_addr        - session control
//               req_*                       - field request (valid/ready)
//               imem_we/ready/addr/wdata    - IMEM write port (valid/ready)
//               busy/done/word_count/err    - status
// ============================================================================
module instr_encoder_loader
  import rv_isa_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stop,
  input  logic [31:0] base_addr,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_fmt,
  input  logic [6:0]  req_opcode,
  input  logic [2:0]  req_funct3,
  input  logic [6:0]  req_funct7,
  input  logic [4:0]  req_rd,
  input  logic [4:0]  req_rs1,
  input  logic [4:0]  req_rs2,
  input  logic [31:0] req_imm,
  output logic        imem_we,
  input  logic        imem_ready,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        busy,
  output logic        done,
  output logic [15:0] word_count,
  output logic        err
);

  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [31:0]        ptr_q, ptr_d;
  logic [15:0]        wc_q, wc_d;
  logic               err_q, err_d;

  logic [AW:0]        fifo_count;
  logic               fifo_full;
  logic               fifo_empty;
  logic [31:0]        fifo_head;

  fmt_e               w_fmt;
  logic signed [31:0] w_imm;
  logic [31:0]        w_word;
  logic               w_legal;
  logic               w_accept;
  logic               w_push;
  logic               w_pop;
  logic               w_unused_addr_lsb;

  // Word alignment: the low address bits are deliberately discarded.
  assign w_unused_addr_lsb = ^base_addr[1:0];

  // --------------------------------------------------------------------------
  // Format packing and immediate range checks
  // --------------------------------------------------------------------------
  assign w_fmt = fmt_e'(req_fmt);
  assign w_imm = $signed(req_imm);

  always_comb begin
    w_word  = 32'd0;
    w_legal = 1'b0;
    case (w_fmt)
      FMT_R: begin
        w_word  = {req_funct7, req_rs2, req_rs1, req_funct3, req_rd, req_opcode};
        w_legal = 1'b1;
      end
      FMT_I: begin
        w_word  = {req_imm[11:0], req_rs1, req_funct3, req_rd, req_opcode};
        w_legal = (w_imm >= IMM12_MIN) && (w_imm <= IMM12_MAX);
      end
      FMT_S: begin
        w_word  = {req_imm[11:5], req_rs2, req_rs1, req_funct3, req_imm[4:0],
                   req_opcode};
        w_legal = (w_imm >= IMM12_MIN) && (w_imm <= IMM12_MAX);
      end
      FMT_B: begin
        w_word  = {req_imm[12], req_imm[10:5], req_rs2, req_rs1, req_funct3,
                   req_imm[4:1], req_imm[11], req_opcode};
        w_legal = (w_imm >= IMM13_MIN) && (w_imm <= IMM13_MAX) && !req_imm[0];
      end
      FMT_U: begin
        w_word  = {req_imm[31:12], req_rd, req_opcode};
        w_legal = (req_imm[11:0] == 12'd0);
      end
      FMT_J: begin
        w_word  = {req_imm[20], req_imm[10:1], req_imm[11], req_imm[19:12],
                   req_rd, req_opcode};
        w_legal = (w_imm >= IMM21_MIN) && (w_imm <= IMM21_MAX) && !req_imm[0];
      end
      default: begin
        w_word  = 32'd0;
        w_legal = 1'b0;
      end
    endcase
  end

  // Full check ignores a same-cycle pop, keeping req_ready purely registered.
  assign req_ready = (state_q == S_RUN) && !fifo_full;
  assign w_accept  = req_valid && req_ready;
  assign w_push    = w_accept && w_legal;
  assign w_pop     = imem_we && imem_ready;

  instr_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (w_push),
    .wdata_i (w_word),
    .pop_i   (w_pop),
    .rdata_o (fifo_head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // --------------------------------------------------------------------------
  // Session control
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    wc_d    = wc_q;
    err_d   = err_q;

    if (w_pop) begin
      ptr_d = ptr_q + 32'd4;
      if (wc_q != 16'hFFFF) begin
        wc_d = wc_q + 16'd1;
      end
    end
    if (w_accept && !w_legal) begin
      err_d = 1'b1;
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        // start wins over a simultaneous stop here.
        if (start) begin
          state_d = S_RUN;
          ptr_d   = {base_addr[31:2], 2'b00};
          wc_d    = 16'd0;
          err_d   = 1'b0;
        end
      end
      S_RUN: begin
        if (stop) begin
          state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        // Leave as soon as the last word's handshake completes so that done
        // rises in the very next cycle.
        if (fifo_empty || ((fifo_count == (AW+1)'(1)) && w_pop)) begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= 32'd0;
      wc_q    <= 16'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      wc_q    <= wc_d;
      err_q   <= err_d;
    end
  end

  assign imem_we    = !fifo_empty;
  assign imem_addr  = ptr_q;
  assign imem_wdata = fifo_head;
  assign busy       = (state_q == S_RUN) || (state_q == S_FLUSH);
  assign done       = (state_q == S_DONE);
  assign word_count = wc_q;
  assign err        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_instr_encoder_loader
// Description : Self-checking bench for instr_encoder_loader. Directed table
//               vectors, multi-cycle corner sequences and a randomized session
//               checked against an arithmetic encoding model and a write
//               scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_encoder_loader;
  import rv_isa_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, start, stop, req_valid, imem_ready;
  logic [31:0] base_addr, req_imm;
  logic [2:0]  req_fmt, req_funct3;
  logic [6:0]  req_opcode, req_funct7;
  logic [4:0]  req_rd, req_rs1, req_rs2;
  logic        req_ready, imem_we, busy, done, err;
  logic [31:0] imem_addr, imem_wdata;
  logic [15:0] word_count;

  instr_encoder_loader #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .base_addr(base_addr),
    .req_valid(req_valid), .req_ready(req_ready), .req_fmt(req_fmt),
    .req_opcode(req_opcode), .req_funct3(req_funct3), .req_funct7(req_funct7),
    .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm),
    .imem_we(imem_we), .imem_ready(imem_ready), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .busy(busy), .done(done), .word_count(word_count),
    .err(err)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_addr = 32'd0;
  int          exp_wc = 0;
  logic        exp_err = 1'b0;
  logic        cur_legal = 1'b0;
  logic [31:0] cur_word = 32'd0;
  logic        rand_ready = 1'b0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_addr = 32'd0, prev_data = 32'd0;

  typedef struct {
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic        legal;
    logic [31:0] word;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- reference model (field arithmetic) ----------------
  function automatic longint fld(input longint v, input int hi, input int lo);
    return (v >> lo) & ((64'sd1 << (hi - lo + 1)) - 1);
  endfunction

  function automatic bit model_legal(input int fmt, input int imm);
    case (fmt)
      0:       return 1'b1;
      1, 2:    return (imm >= -2048) && (imm <= 2047);
      3:       return (imm >= -4096) && (imm <= 4094) && ((imm & 1) == 0);
      4:       return (imm & 32'hFFF) == 0;
      5:       return (imm >= -(1 << 20)) && (imm <= (1 << 20) - 2) && ((imm & 1) == 0);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] model_word(input int fmt, input int op, input int f3,
      input int f7, input int rd, input int rs1, input int rs2, input int imm);
    longint v = imm;
    longint w = op;
    case (fmt)
      0: w += (rd << 7) + (f3 << 12) + (rs1 << 15) + (rs2 << 20) + (f7 << 25);
      1: w += (rd << 7) + (f3 << 12) + (rs1 << 15) + (fld(v, 11, 0) << 20);
      2: w += (fld(v, 4, 0) << 7) + (f3 << 12) + (rs1 << 15) + (rs2 << 20) + (fld(v, 11, 5) << 25);
      3: w += (fld(v, 11, 11) << 7) + (fld(v, 4, 1) << 8) + (f3 << 12) + (rs1 << 15)
              + (rs2 << 20) + (fld(v, 10, 5) << 25) + (fld(v, 12, 12) << 31);
      4: w += (rd << 7) + (fld(v, 31, 12) << 12);
      5: w += (rd << 7) + (fld(v, 19, 12) << 12) + (fld(v, 11, 11) << 20)
              + (fld(v, 10, 1) << 21) + (fld(v, 20, 20) << 31);
      default: w = 0;
    endcase
    return w[31:0];
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_we_hold", imem_we, 1'b1);
        check("stall_addr_hold", imem_addr, prev_addr);
        check("stall_data_hold", imem_wdata, prev_data);
      end
      if (req_valid && req_ready) begin
        if (cur_legal) exp_q.push_back(cur_word);
        else exp_err = 1'b1;
      end
      if (imem_we && imem_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", imem_wdata, 32'hDEAD_BEEF);
        end else begin
          check("write_data", imem_wdata, exp_q.pop_front());
          check("write_addr", imem_addr, exp_addr);
          exp_addr = exp_addr + 32'd4;
          if (exp_wc < 65535) exp_wc++;
        end
      end
      prev_stall = imem_we && !imem_ready;
      prev_addr  = imem_addr;
      prev_data  = imem_wdata;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) imem_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic start_session(input logic [31:0] base);
    exp_q.delete();
    exp_addr  = {base[31:2], 2'b00};
    exp_wc    = 0;
    exp_err   = 1'b0;
    base_addr = base;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic send_req(input vec_t v, input logic with_stop);
    logic acc = 1'b0;
    req_fmt = v.fmt; req_opcode = v.op; req_funct3 = v.f3; req_funct7 = v.f7;
    req_rd = v.rd; req_rs1 = v.rs1; req_rs2 = v.rs2; req_imm = v.imm;
    cur_legal = v.legal;
    cur_word  = v.word;
    req_valid = 1'b1;
    stop      = with_stop;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      acc = req_ready;
      tick();
      stop = 1'b0;
    end
    req_valid = 1'b0;
    if (!acc) check("req_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic finish_session(input logic do_stop);
    if (do_stop) begin
      stop = 1'b1;
      tick();
      stop = 1'b0;
    end
    for (int i = 0; i < 300 && !done; i++) tick();
    check("done_reached", done, 1'b1);
    check("busy_after_done", busy, 1'b0);
    check("word_count", word_count, exp_wc);
    check("err_sticky", err, exp_err);
    check("scoreboard_drained", exp_q.size(), 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_req_ready"}, req_ready, 1'b0);
    check({tag, "_imem_we"}, imem_we, 1'b0);
    check({tag, "_imem_addr"}, imem_addr, 32'd0);
    check({tag, "_imem_wdata"}, imem_wdata, 32'd0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_word_count"}, word_count, 32'd0);
    check({tag, "_err"}, err, 1'b0);
  endtask

  function automatic vec_t mk(input int fmt, input int op, input int f3, input int f7,
      input int rd, input int rs1, input int rs2, input int imm, input bit legal,
      input logic [31:0] word);
    vec_t v;
    v.fmt = 3'(fmt); v.op = 7'(op); v.f3 = 3'(f3); v.f7 = 7'(f7);
    v.rd = 5'(rd); v.rs1 = 5'(rs1); v.rs2 = 5'(rs2); v.imm = imm;
    v.legal = legal; v.word = word;
    return v;
  endfunction

  // Model-derived vector, used for the non-table sequences.
  function automatic vec_t mkm(input int fmt, input int op, input int f3, input int f7,
      input int rd, input int rs1, input int rs2, input int imm);
    return mk(fmt, op, f3, f7, rd, rs1, rs2, imm, model_legal(fmt, imm),
              model_word(fmt, op, f3, f7, rd, rs1, rs2, imm));
  endfunction

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t v;
    int   bnd[8] = '{-2048, 2047, -4096, 4094, -1048576, 1048574, 2048, 4096};

    rst_n = 1'b0; start = 1'b0; stop = 1'b0; base_addr = 32'd0; req_valid = 1'b0;
    req_fmt = 3'd0; req_opcode = 7'd0; req_funct3 = 3'd0; req_funct7 = 7'd0;
    req_rd = 5'd0; req_rs1 = 5'd0; req_rs2 = 5'd0; req_imm = 32'd0; imem_ready = 1'b1;

    // Directed table: {fmt, op, f3, f7, rd, rs1, rs2, imm, legal, word}
    tbl.push_back(mk(1, 'h13, 0, 0, 1, 0, 0, 5,          1, 32'h00500093));
    tbl.push_back(mk(2, 'h23, 2, 0, 0, 1, 2, 8,          1, 32'h0020A423));
    tbl.push_back(mk(5, 'h6F, 0, 0, 1, 0, 0, 8,          1, 32'h008000EF));
    tbl.push_back(mk(3, 'h63, 0, 0, 0, 1, 2, 3,          0, 32'h0));
    tbl.push_back(mk(4, 'h37, 0, 0, 5, 0, 0, 'h12345000, 1, 32'h123452B7));
    tbl.push_back(mk(0, 'h33, 0, 0, 3, 1, 2, 0,          1, 32'h002081B3));
    tbl.push_back(mk(0, 'h33, 0, 'h20, 3, 1, 2, 0,       1, 32'h402081B3));
    tbl.push_back(mk(1, 'h13, 0, 0, 1, 0, 0, -1,         1, 32'hFFF00093));
    tbl.push_back(mk(1, 'h13, 0, 0, 1, 0, 0, 2048,       0, 32'h0));
    tbl.push_back(mk(1, 'h13, 0, 0, 1, 0, 0, -2048,      1, 32'h80000093));
    tbl.push_back(mk(3, 'h63, 0, 0, 0, 1, 2, 8,          1, 32'h00208463));
    tbl.push_back(mk(3, 'h63, 0, 0, 0, 0, 0, -4096,      1, 32'h80000063));
    tbl.push_back(mk(3, 'h63, 0, 0, 0, 0, 0, 4096,       0, 32'h0));
    tbl.push_back(mk(5, 'h6F, 0, 0, 0, 0, 0, -2,         1, 32'hFFFFF06F));
    tbl.push_back(mk(5, 'h6F, 0, 0, 0, 0, 0, 1048574,    1, 32'h7FFFF06F));
    tbl.push_back(mk(5, 'h6F, 0, 0, 0, 0, 0, 1048576,    0, 32'h0));
    tbl.push_back(mk(5, 'h6F, 0, 0, 0, 0, 0, 1,          0, 32'h0));
    tbl.push_back(mk(4, 'h37, 0, 0, 5, 0, 0, 'h00001001, 0, 32'h0));
    tbl.push_back(mk(6, 'h13, 0, 0, 1, 0, 0, 0,          0, 32'h0));
    tbl.push_back(mk(2, 'h23, 0, 0, 0, 0, 0, -2048,      1, 32'h80000023));

    repeat (3) tick();
    check_reset_values("reset");
    rst_n = 1'b1;
    tick();

    // addi x1,x0,5 at 0x100
    start_session(32'h100);
    send_req(tbl[0], 1'b0);
    finish_session(1'b1);
    check("tp1_count", word_count, 32'd1);

    // S then J
    start_session(32'h100);
    send_req(tbl[1], 1'b0);
    send_req(tbl[2], 1'b0);
    finish_session(1'b1);
    check("tp2_count", word_count, 32'd2);

    // misaligned B dropped, U written
    start_session(32'h100);
    send_req(tbl[3], 1'b0);
    send_req(tbl[4], 1'b0);
    finish_session(1'b1);
    check("tp3_err", err, 1'b1);
    check("tp3_count", word_count, 32'd1);

    // Whole table in one session; base low bits must be dropped.
    start_session(32'h103);
    foreach (tbl[i]) begin
      send_req(tbl[i], 1'b0);
      check("table_err", err, exp_err);
    end
    finish_session(1'b1);

    // Back-pressure: 4 accepts then req_ready falls, outputs hold.
    imem_ready = 1'b0;
    start_session(32'h400);
    for (int i = 0; i < 4; i++) send_req(mkm(1, 'h13, 0, 0, i + 1, 0, 0, i * 3), 1'b0);
    tick(); tick();
    check("full_req_ready", req_ready, 1'b0);
    check("full_imem_we", imem_we, 1'b1);
    check("full_imem_addr", imem_addr, 32'h400);
    imem_ready = 1'b1;
    for (int i = 4; i < 6; i++) send_req(mkm(1, 'h13, 0, 0, i + 1, 0, 0, i * 3), 1'b0);
    finish_session(1'b1);
    check("bp_count", word_count, 32'd6);

    // Address wrap at the top of memory.
    start_session(32'hFFFF_FFFC);
    send_req(mkm(0, 'h33, 0, 0, 1, 2, 3, 0), 1'b0);
    send_req(mkm(0, 'h33, 0, 0, 4, 5, 6, 0), 1'b0);
    finish_session(1'b1);

    // stop in the same cycle as an accepted request: still written.
    start_session(32'h500);
    send_req(mkm(4, 'h37, 0, 0, 7, 0, 0, 'h0ABCD000), 1'b1);
    finish_session(1'b0);
    check("stop_accept_count", word_count, 32'd1);

    // Empty FLUSH reaches DONE in one cycle.
    start_session(32'h600);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("flush_busy", busy, 1'b1);
    check("flush_done", done, 1'b0);
    tick();
    check("flush_to_done", done, 1'b1);
    check("flush_busy_low", busy, 1'b0);

    // start with stop in DONE: start wins.
    stop = 1'b1;
    start_session(32'h680);
    stop = 1'b0;
    check("startstop_busy", busy, 1'b1);
    check("startstop_done", done, 1'b0);
    send_req(mkm(1, 'h13, 0, 0, 2, 0, 0, 9), 1'b0);
    finish_session(1'b1);

    // Reset with 3 queued words: nothing stale comes out.
    imem_ready = 1'b0;
    start_session(32'h700);
    for (int i = 0; i < 3; i++) send_req(mkm(1, 'h13, 0, 0, i, 0, 0, i), 1'b0);
    rst_n = 1'b0;
    tick(); tick();
    exp_q.delete();
    check_reset_values("midreset");
    rst_n = 1'b1;
    imem_ready = 1'b1;
    repeat (5) tick();
    check("no_stale_we", imem_we, 1'b0);
    start_session(32'h800);
    send_req(mkm(1, 'h13, 0, 0, 1, 0, 0, 5), 1'b0);
    finish_session(1'b1);

    // Randomized session with random back-pressure.
    rand_ready = 1'b1;
    start_session($urandom & 32'hFFFF_FFF0);
    for (int n = 0; n < 60; n++) begin
      int fmt = int'($urandom_range(0, 7));
      int imm;
      case ($urandom_range(0, 4))
        0: imm = int'($urandom_range(0, 8200)) - 4100;
        1: imm = int'($urandom);
        2: imm = int'($urandom & 32'hFFFF_F000);
        3: imm = int'($urandom_range(0, (1 << 21) + 4)) - (1 << 20) - 2;
        default: imm = bnd[$urandom_range(0, 7)];
      endcase
      v = mkm(fmt, int'($urandom_range(0, 127)), int'($urandom_range(0, 7)),
              int'($urandom_range(0, 127)), int'($urandom_range(0, 31)),
              int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), imm);
      send_req(v, 1'b0);
    end
    finish_session(1'b1);
    rand_ready = 1'b0;
    imem_ready = 1'b1;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
